// File: rtl/rtc_addr_sequencer.sv
// RTC register-address sequencer: sweeps Address_WR over FIRST_IDX..LAST_IDX, one bus
// transaction per index. Optional REQ watchdog enabled by defining RTC_SEQ_TIMEOUT_EN.
module rtc_addr_sequencer #(
    parameter int FIRST_IDX      = 0,
    parameter int LAST_IDX       = 15,
    parameter int GAP_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode_wr,
    input  logic       abort,
    input  logic       bus_ack,
    output logic [3:0] Address_WR,
    output logic       bus_req,
    output logic       bus_wr,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    localparam logic [3:0] FIRST   = 4'(FIRST_IDX);
    localparam logic [3:0] LAST    = 4'(LAST_IDX);
    localparam logic [3:0] GAP_END = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t     state, state_nx;
    logic [3:0] idx, idx_nx;
    logic [3:0] gap_cnt, gap_nx;
    logic       wr_q, wr_nx;

`ifdef RTC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt, to_nx;
    logic          err_q, err_nx;
`endif

    // NOTE: every variable driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        gap_nx   = gap_cnt;
        wr_nx    = wr_q;
`ifdef RTC_SEQ_TIMEOUT_EN
        to_nx    = to_cnt;
        err_nx   = err_q;
`endif
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = REQ;
                    idx_nx   = FIRST;
                    wr_nx    = mode_wr;
`ifdef RTC_SEQ_TIMEOUT_EN
                    to_nx    = '0;
                    err_nx   = 1'b0;
`endif
                end
            end
            REQ: begin
                if (abort) begin
                    state_nx = IDLE;
                    idx_nx   = FIRST;
                end else if (bus_ack) begin
                    if (idx == LAST) begin
                        state_nx = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_nx = GAP;
                        gap_nx   = '0;
                    end else begin
                        // Zero gap: next request follows immediately, bus_req stays high.
                        idx_nx   = idx + 4'd1;
`ifdef RTC_SEQ_TIMEOUT_EN
                        to_nx    = '0;
`endif
                    end
                end
`ifdef RTC_SEQ_TIMEOUT_EN
                else if (to_cnt == TO_END) begin
                    state_nx = IDLE;
                    idx_nx   = FIRST;
                    err_nx   = 1'b1;
                end else begin
                    to_nx = to_cnt + 1'b1;
                end
`endif
            end
            GAP: begin
                if (abort) begin
                    state_nx = IDLE;
                    idx_nx   = FIRST;
                end else if (gap_cnt == GAP_END) begin
                    state_nx = REQ;
                    idx_nx   = idx + 4'd1;
`ifdef RTC_SEQ_TIMEOUT_EN
                    to_nx    = '0;
`endif
                end else begin
                    gap_nx = gap_cnt + 4'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                idx_nx   = FIRST;
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = FIRST;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= FIRST;
            gap_cnt <= '0;
            wr_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            gap_cnt <= gap_nx;
            wr_q    <= wr_nx;
        end
    end

`ifdef RTC_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= to_nx;
            err_q  <= err_nx;
        end
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    // Status outputs decode the state register, so the async reset clears them at once.
    assign Address_WR = idx;
    assign bus_req    = (state == REQ);
    assign busy       = (state == REQ) || (state == GAP);
    assign done       = (state == DONE);
    assign bus_wr     = wr_q;

endmodule

// File: tb/tb_rtc_addr_sequencer.sv
// Scoreboard bench for rtc_addr_sequencer: stimulus queues expected transactions and done
// pulses with hand-computed cycle numbers; a monitor pops and compares on each DUT event.
module tb_rtc_addr_sequencer;

    typedef struct {
        logic       is_done;
        logic [3:0] idx;
        logic       wr;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, start, mode_wr, abort, bus_ack;
    logic [3:0] Address_WR;
    logic       bus_req, bus_wr, busy, done, error;

    logic       s5_start, s5_ack;
    logic [3:0] a5;
    logic       req5, wr5, busy5, done5, err5;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic auto_ack = 1'b1;
    logic extra_ack = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_addr_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mode_wr(mode_wr), .abort(abort),
        .bus_ack(bus_ack), .Address_WR(Address_WR), .bus_req(bus_req), .bus_wr(bus_wr),
        .busy(busy), .done(done), .error(error)
    );

    rtc_addr_sequencer #(.FIRST_IDX(13), .LAST_IDX(13), .GAP_CYCLES(0)) u5 (
        .clk(clk), .reset(reset), .start(s5_start), .mode_wr(mode_wr), .abort(abort),
        .bus_ack(s5_ack), .Address_WR(a5), .bus_req(req5), .bus_wr(wr5),
        .busy(busy5), .done(done5), .error(err5)
    );

`ifdef RTC_SEQ_TIMEOUT_EN
    logic       s6_start;
    logic       s6_ack = 1'b0;
    logic [3:0] a6;
    logic       req6, wr6, busy6, done6, err6;
    rtc_addr_sequencer #(.TIMEOUT_CYCLES(16)) u6 (
        .clk(clk), .reset(reset), .start(s6_start), .mode_wr(mode_wr), .abort(abort),
        .bus_ack(s6_ack), .Address_WR(a6), .bus_req(req6), .bus_wr(wr6),
        .busy(busy6), .done(done6), .error(err6)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Default timing: request k starts 1+5k cycles after start (2 req cycles + 3 gap),
    // done follows the ack of index 15 (cycle 77) at cycle 78.
    task automatic push_sweep(input int t0, input int k_last, input logic wr, input bit with_done);
        exp_t e;
        for (int k = 0; k <= k_last; k++) begin
            e.is_done = 1'b0; e.idx = 4'(k); e.wr = wr; e.cyc = t0 + 1 + 5 * k;
            exp_q.push_back(e);
        end
        if (with_done) begin
            e.is_done = 1'b1; e.idx = 4'd0; e.wr = 1'b0; e.cyc = t0 + 78;
            exp_q.push_back(e);
        end
    endtask

    // Bus controller model: acks on the second cycle of each request, plus injected acks.
    initial begin
        logic       r_prev;
        logic [3:0] r_addr;
        int         rcnt;
        r_prev = 1'b0; r_addr = 4'd0; rcnt = 0; bus_ack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset && bus_req) rcnt = (!r_prev || Address_WR != r_addr) ? 1 : rcnt + 1;
            else rcnt = 0;
            r_prev  = bus_req;
            r_addr  = Address_WR;
            bus_ack = (auto_ack && rcnt == 2) || extra_ack;
        end
    end

    // Monitor: a new transaction (request rise or index change) or a done pulse pops one entry.
    initial begin
        exp_t       e;
        logic       m_prev, new_txn;
        logic [3:0] m_addr;
        m_prev = 1'b0; m_addr = 4'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                new_txn = bus_req && (!m_prev || Address_WR != m_addr);
                if (new_txn || done) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_event", {30'd0, done, bus_req}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_kind", done, e.is_done);
                        check("sb_cycle", cyc, e.cyc);
                        if (!e.is_done) begin
                            check("sb_idx", Address_WR, e.idx);
                            check("sb_bus_wr", bus_wr, e.wr);
                            check("sb_busy", busy, 1);
                        end else begin
                            check("sb_done_busy", busy, 0);
                        end
                    end
                end
            end
            m_prev = bus_req;
            m_addr = Address_WR;
        end
    end

    initial begin
        int t0;
        reset = 1'b0; start = 1'b0; mode_wr = 1'b0; abort = 1'b0;
        s5_start = 1'b0; s5_ack = 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
        s6_start = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_addr", Address_WR, 0);
        check("rst_outputs", {bus_req, bus_wr, busy, done, error}, 0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);

        // Full write sweep with default parameters.
        t0 = cyc; start = 1'b1; mode_wr = 1'b1;
        push_sweep(t0, 15, 1'b1, 1'b1);
        @(negedge clk) begin start = 1'b0; mode_wr = 1'b0; end
        repeat (80) @(negedge clk);
        check("t2_queue_drained", exp_q.size(), 0);

        // Stray start/ack pulses in IDLE, GAP and while busy must not disturb the sweep.
        extra_ack = 1'b1;
        @(negedge clk) extra_ack = 1'b0;
        @(negedge clk);
        t0 = cyc; start = 1'b1; mode_wr = 1'b1;
        push_sweep(t0, 15, 1'b1, 1'b1);
        for (int r = 1; r <= 80; r++) begin
            @(negedge clk);
            start     = (r % 7 == 3) && (r < 75);
            mode_wr   = (r % 2 == 0);
            extra_ack = (((r % 5) == 3 || (r % 5) == 4) && r < 76) || (r == 79);
        end
        @(negedge clk) begin start = 1'b0; mode_wr = 1'b0; extra_ack = 1'b0; end
        repeat (3) @(negedge clk);
        check("t4_queue_drained", exp_q.size(), 0);

        // Read sweep aborted in REQ at index 7, same cycle as the ack.
        t0 = cyc; start = 1'b1; mode_wr = 1'b0;
        push_sweep(t0, 7, 1'b0, 1'b0);
        for (int r = 1; r <= 37; r++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (r == 37);
        end
        @(negedge clk) abort = 1'b0;
        check("t3_bus_req", bus_req, 0);
        check("t3_busy", busy, 0);
        check("t3_addr", Address_WR, 0);
        check("t3_done", done, 0);
        repeat (85) @(negedge clk);
        check("t3_queue_drained", exp_q.size(), 0);

        // Asynchronous reset while requesting index 5.
        t0 = cyc; start = 1'b1; mode_wr = 1'b1;
        push_sweep(t0, 5, 1'b1, 1'b0);
        for (int r = 1; r <= 26; r++) begin
            @(negedge clk);
            start = 1'b0; mode_wr = 1'b0;
        end
        check("t1_pre_req", bus_req, 1);
        check("t1_pre_addr", Address_WR, 5);
        #2 reset = 1'b0;
        #1;
        check("t1_addr", Address_WR, 0);
        check("t1_outputs", {bus_req, bus_wr, busy, done, error}, 0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_queue_drained", exp_q.size(), 0);

        // Single-index sweep with zero gap.
        s5_start = 1'b1; mode_wr = 1'b1;
        @(negedge clk) begin s5_start = 1'b0; mode_wr = 1'b0; end
        check("t5_req_c1", {req5, busy5, wr5}, 3'b111);
        check("t5_addr_c1", a5, 13);
        @(negedge clk) s5_ack = 1'b1;
        check("t5_req_c2", req5, 1);
        check("t5_addr_c2", a5, 13);
        @(negedge clk) s5_ack = 1'b0;
        check("t5_done_c3", {done5, busy5, req5}, 3'b100);
        @(negedge clk);
        check("t5_after_c4", {done5, busy5, req5}, 3'b000);
        check("t5_addr_c4", a5, 13);

`ifdef RTC_SEQ_TIMEOUT_EN
        // Ack withheld: watchdog fires after 16 request cycles; next start clears error.
        s6_start = 1'b1;
        for (int r = 1; r <= 16; r++) begin
            @(negedge clk);
            s6_start = 1'b0;
        end
        check("t6_req_c16", {req6, err6}, 2'b10);
        @(negedge clk);
        check("t6_timeout", {req6, busy6, done6, err6}, 4'b0001);
        s6_start = 1'b1;
        @(negedge clk) s6_start = 1'b0;
        check("t6_restart", {req6, err6}, 2'b10);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("t6_abort", {req6, err6}, 2'b00);
`endif

        check("main_error", error, 0);
        check("final_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
